// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480@60 Hz raster generator.
// Holds the default porch/sync sizes, derived totals, sync window edges,
// the coordinate/frame counter widths and the sync payload type.
package vga_timing_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned MAX_SYNC_DELAY = 4;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync windows are [start, end): 656..751 and 490..491 with the defaults.
  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam int unsigned SYNC_W = 2;

  // Active-low sync pair carried through the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the renderers/connector.
//   DrawX/DrawY : current pixel column/line
//   blank       : 1 while in the visible region
//   hs/vs       : delayed active-low syncs
//   sof         : start-of-frame strobe at (0,0)
//   frame_cnt   : frame counter, advances with sof
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0]     DrawX;
  logic [COORD_W-1:0]     DrawY;
  logic                   blank;
  logic                   hs;
  logic                   vs;
  logic                   sof;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output DrawX, DrawY, blank, hs, vs, sof, frame_cnt
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, sof, frame_cnt
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align syncs with registered RGB.
//   clk, rst_n : clock, asynchronous active-low reset (stages reset to 1)
//   d_i        : WIDTH-bit input
//   q_o        : input delayed by DEPTH clocks (pass-through when DEPTH = 0)
module sync_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    // No storage: clock and reset are intentionally unused here.
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign q_o       = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Reset to all-ones so active-low syncs stay deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '1;
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60 Hz from a 25 MHz clock).
//   vga_clk : pixel clock
//   reset_n : asynchronous active-low reset
//   vga     : timing bundle (DrawX, DrawY, blank, hs, vs, sof, frame_cnt)
// All flags are registered from the next counter values so they line up
// with DrawX/DrawY; hs/vs then pass through SYNC_DELAY extra stages.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0]     hc_q, hc_d;
  logic [COORD_W-1:0]     vc_q, vc_d;
  logic                   blank_q, blank_d;
  logic                   hs_raw_q, hs_raw_d;
  logic                   vs_raw_q, vs_raw_d;
  logic                   sof_q, sof_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  sync_t sync_raw;
  sync_t sync_dly;

  // Next counter position and the flags decoded from it.
  always_comb begin
    hc_d        = hc_q + COORD_W'(1);
    vc_d        = vc_q;
    frame_cnt_d = frame_cnt_q;

    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + COORD_W'(1);
    end

    blank_d  = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_raw_d = !((hc_d >= H_SYNC_LO) && (hc_d < H_SYNC_HI));
    vs_raw_d = !((vc_d >= V_SYNC_LO) && (vc_d < V_SYNC_HI));
    sof_d    = (hc_d == '0) && (vc_d == '0);

    if (sof_d) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q        <= H_LAST;
      vc_q        <= V_LAST;
      blank_q     <= 1'b0;
      hs_raw_q    <= 1'b1;
      vs_raw_q    <= 1'b1;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      blank_q     <= blank_d;
      hs_raw_q    <= hs_raw_d;
      vs_raw_q    <= vs_raw_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sync_raw = '{hs: hs_raw_q, vs: vs_raw_q};

  sync_delay_line #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (SYNC_W)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d_i   (sync_raw),
    .q_o   (sync_dly)
  );

  assign vga.DrawX     = hc_q;
  assign vga.DrawY     = vc_q;
  assign vga.blank     = blank_q;
  assign vga.sof       = sof_q;
  assign vga.frame_cnt = frame_cnt_q;
  assign vga.hs        = sync_dly.hs;
  assign vga.vs        = sync_dly.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: one default-size generator plus three reduced-raster
// generators (SYNC_DELAY 0, 1, 4) driven by one clock/reset with random
// asynchronous resets. Expected outputs come from the raster position
// computed as the number of clock edges since reset.
module tb_vga_timing_gen;

  // Reduced raster so many frames fit in a short run.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

  logic vga_clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_0 ();
  vga_timing_gen_if if_1 ();
  vga_timing_gen_if if_4 ();

  vga_timing_gen dut_def (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_def)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .SYNC_DELAY (0)
  ) dut_d0 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_0)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .SYNC_DELAY (1)
  ) dut_d1 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_1)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .SYNC_DELAY (4)
  ) dut_d4 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_4)
  );

  always #5 vga_clk = ~vga_clk;

  // Edges since the last reset; 0 means "in reset / reset values".
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) t <= 0;
    else          t <= t + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // Undelayed sync level at raster step tt (tt < 1 is reset: deasserted).
  function automatic logic hs_raw_at(input int ht, input int vt, input int lo, input int w, input int tt);
    int hc;
    if (tt < 1) return 1'b1;
    hc = ((tt - 1) % (ht * vt)) % ht;
    return !(hc >= lo && hc < lo + w);
  endfunction

  function automatic logic vs_raw_at(input int ht, input int vt, input int lo, input int w, input int tt);
    int vc;
    if (tt < 1) return 1'b1;
    vc = ((tt - 1) % (ht * vt)) / ht;
    return !(vc >= lo && vc < lo + w);
  endfunction

  task automatic check_dut(input string tag,
                           input int hv, input int hf, input int hs, input int hb,
                           input int vv, input int vf, input int vs, input int vb,
                           input int d, input int tt,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic bl, input logic h, input logic v,
                           input logic so, input logic [7:0] fc);
    int ht, vt, pix, ex, ey, efc;
    logic ebl, eso, eh, ev;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (tt == 0) begin
      ex = ht - 1; ey = vt - 1; ebl = 1'b0; eso = 1'b0; efc = 0;
    end else begin
      pix = (tt - 1) % (ht * vt);
      ex  = pix % ht;
      ey  = pix / ht;
      ebl = (ex < hv) && (ey < vv);
      eso = (pix == 0);
      efc = ((tt - 1) / (ht * vt) + 1) % 256;
    end
    eh = hs_raw_at(ht, vt, hv + hf, hs, tt - d);
    ev = vs_raw_at(ht, vt, vv + vf, vs, tt - d);
    check({tag, ".DrawX"},     32'(x),   32'(ex));
    check({tag, ".DrawY"},     32'(y),   32'(ey));
    check({tag, ".blank"},     32'(bl),  32'(ebl));
    check({tag, ".hs"},        32'(h),   32'(eh));
    check({tag, ".vs"},        32'(v),   32'(ev));
    check({tag, ".sof"},       32'(so),  32'(eso));
    check({tag, ".frame_cnt"}, 32'(fc),  32'(efc));
  endtask

  // Per-frame aggregates on the zero-delay instance, and frame counter wrap.
  int   vis_cnt = 0, hs_low = 0, vs_low = 0, frames_checked = 0;
  bit   agg_full = 1'b0;
  bit   wrap_seen = 1'b0;
  logic [7:0] prev_fc = '0;

  always @(negedge vga_clk) begin
    check_dut("def", 640, 16, 96, 48, 480, 10, 2, 33, 1, t,
              if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs, if_def.vs,
              if_def.sof, if_def.frame_cnt);
    check_dut("d0", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 0, t,
              if_0.DrawX, if_0.DrawY, if_0.blank, if_0.hs, if_0.vs,
              if_0.sof, if_0.frame_cnt);
    check_dut("d1", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1, t,
              if_1.DrawX, if_1.DrawY, if_1.blank, if_1.hs, if_1.vs,
              if_1.sof, if_1.frame_cnt);
    check_dut("d4", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 4, t,
              if_4.DrawX, if_4.DrawY, if_4.blank, if_4.hs, if_4.vs,
              if_4.sof, if_4.frame_cnt);

    if (!reset_n) begin
      agg_full = 1'b0;
      vis_cnt  = 0; hs_low = 0; vs_low = 0;
      prev_fc  = '0;
    end else begin
      if (if_0.sof === 1'b1) begin
        if (agg_full) begin
          check("frame.visible", 32'(vis_cnt), 32'(S_HV * S_VV));
          check("frame.hs_low",  32'(hs_low),  32'(S_VT * S_HS));
          check("frame.vs_low",  32'(vs_low),  32'(S_VS * S_HT));
          frames_checked++;
        end
        agg_full = 1'b1;
        vis_cnt  = 0; hs_low = 0; vs_low = 0;
      end
      vis_cnt += (if_0.blank === 1'b1) ? 1 : 0;
      hs_low  += (if_0.hs === 1'b0) ? 1 : 0;
      vs_low  += (if_0.vs === 1'b0) ? 1 : 0;
      if (if_1.sof === 1'b1 && if_1.frame_cnt === 8'd0 && prev_fc === 8'd255)
        wrap_seen = 1'b1;
      prev_fc = if_1.frame_cnt;
    end
  end

  // Assert reset asynchronously between edges and confirm immediate response.
  task automatic async_reset(input int hold);
    @(posedge vga_clk);
    #($urandom_range(1, 4));
    reset_n = 1'b0;
    #1;
    check("async.def.DrawX", 32'(if_def.DrawX), 32'd799);
    check("async.def.DrawY", 32'(if_def.DrawY), 32'd524);
    check("async.def.blank", 32'(if_def.blank), 32'd0);
    check("async.def.hs",    32'(if_def.hs),    32'd1);
    check("async.def.vs",    32'(if_def.vs),    32'd1);
    check("async.d4.hs",     32'(if_4.hs),      32'd1);
    check("async.d4.vs",     32'(if_4.vs),      32'd1);
    check("async.d1.fcnt",   32'(if_1.frame_cnt), 32'd0);
    repeat (hold) @(negedge vga_clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int tx, ty, budget;
    bit found;

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (5) @(negedge vga_clk);
    #1 reset_n = 1'b1;

    @(posedge vga_clk);
    #1;
    check("first.DrawX", 32'(if_def.DrawX),     32'd0);
    check("first.DrawY", 32'(if_def.DrawY),     32'd0);
    check("first.blank", 32'(if_def.blank),     32'd1);
    check("first.sof",   32'(if_def.sof),       32'd1);
    check("first.fcnt",  32'(if_def.frame_cnt), 32'd1);

    // A couple of full default-size lines.
    repeat (2000) @(posedge vga_clk);

    // Random mid-frame resets at random small-raster positions.
    for (int k = 0; k < 6; k++) begin
      tx = $urandom_range(0, S_HT - 1);
      ty = $urandom_range(0, S_VT - 1);
      found = 1'b0;
      budget = 3 * S_HT * S_VT;
      while (!found && budget > 0) begin
        @(negedge vga_clk);
        if (if_1.DrawX == 10'(tx) && if_1.DrawY == 10'(ty)) found = 1'b1;
        budget--;
      end
      check("wait_pos.found", 32'(found), 32'd1);
      async_reset($urandom_range(1, 5));
      repeat ($urandom_range(10, 400)) @(posedge vga_clk);
    end

    // Enough frames to wrap the 8-bit frame counter.
    repeat (260 * S_HT * S_VT) @(posedge vga_clk);
    @(negedge vga_clk);

    check("frame_cnt.wrap_seen", 32'(wrap_seen), 32'd1);
    check("frame.any_checked", 32'(frames_checked > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
